// File: rtl/seq_detector_param.sv
// Runtime-configurable Moore serial-pattern detector with saturating match counter; detector_out is 1 cycle after the final bit.
// No backpressure: bits are consumed whenever in_valid is high, and idle cycles hold the history.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             clear_count,
    output logic             detector_out,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] len;
    logic             overlap;

    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_inc;
    logic             match;

    assign hist_next = {hist[PAT_W-2:0], sequence_in};
    assign fill_inc  = (fill == LEN_MAX) ? fill : fill + 1'b1;

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
    end

    assign match = in_valid && !cfg_load && !cfg_err && (fill_inc >= len) &&
                   (((hist_next ^ pat) & mask) == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist         <= '0;
            fill         <= '0;
            pat          <= '0;
            len          <= '0;
            overlap      <= 1'b1;
            detector_out <= 1'b0;
            cfg_err      <= 1'b1;
        end else if (cfg_load) begin
            pat          <= cfg_pattern;
            len          <= cfg_len;
            overlap      <= cfg_overlap;
            cfg_err      <= (cfg_len == '0) || (cfg_len > LEN_MAX);
            hist         <= '0;
            fill         <= '0;
            detector_out <= 1'b0;
        end else if (in_valid) begin
            hist         <= hist_next;
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            fill         <= (match && !overlap) ? '0 : fill_inc;
            detector_out <= match;
        end else begin
            detector_out <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            match_count <= '0;
        end else if (clear_count) begin
            match_count <= '0;
        end else if (match && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector; successor to the fixed-pattern SD block.
- Pattern, pattern length and overlap mode are loaded at runtime, with a valid qualifier on the serial input.
- Counts matches and flags bad configuration.
- Sits between a serial bit source (deserialiser/UART shifter) and control logic that consumes the per-match pulse and the count.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 16, width of match counter (>=1)
LEN_W, $clog2(PAT_W+1), width of length field (derived, not overridden)

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock)
sequence_in  input  1  serial data bit
in_valid  input  1  sequence_in is sampled only when 1
cfg_load  input  1  one-cycle pulse: latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  PAT_W  pattern; bit [len-1] is first-received bit, bit [0] last
cfg_len  input  LEN_W  active pattern length, legal 1..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
clear_count  input  1  synchronous clear of match_count
detector_out  output  1  registered one-cycle match pulse (Moore)
match_count  output  CNT_W  saturating number of matches
cfg_err  output  1  latched config illegal (len 0 or >PAT_W)

Behaviour:
- Reset (reset==0 at edge): history=0, fill=0, active pattern=0, len=0, overlap=1, detector_out=0, match_count=0, cfg_err=1 (no legal config yet, so no detection until first legal cfg_load).
- State: history shift reg hist[PAT_W-1:0]; fill counter 0..PAT_W = valid bits since last clear, saturating at PAT_W.
- Accepted bit (in_valid=1, no cfg_load): hist <= {hist[PAT_W-2:0], sequence_in}; fill <= min(fill+1, PAT_W).
- in_valid=0: hist and fill hold; detector_out goes 0 next cycle.
- Match condition, evaluated on the post-shift history at an accepted-bit edge: cfg_err==0 AND fill_next >= len AND hist_next[len-1:0] == pattern[len-1:0].
- detector_out: registered match condition; high exactly the cycle after the edge sampling the final pattern bit; one cycle per match; never high on cycles without an accepted bit at the prior edge.
- Overlap=1: history untouched after a match (e.g. 1011 in 1011011 matches twice).
- Overlap=0: on a match, fill <= 0 at the same edge, so the next match needs len fresh bits.
- match_count: +1 per match, saturates at 2^CNT_W-1. clear_count has priority over a same-cycle increment (result 0).
- cfg_load:
  - Latches pattern, len and overlap; cfg_err <= (cfg_len==0 || cfg_len>PAT_W).
  - Clears hist and fill; the bit presented that cycle is discarded.
  - No match is evaluated that cycle; detector_out=0 next cycle.
  - match_count unaffected.
- Pattern bits above len are ignored.
- Reset mid-stream discards the partial sequence; after reset a full-length sequence is needed.

Test Plan:
- Pattern 4'b1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 (valid every cycle) -> detector_out pulses after bits 4 and 7; match_count=2.
- Same config, overlap=0, stream 1,0,1,1,0,1,1 -> single pulse after bit 4; count=1. Then stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8.
- Overlap=1, stream 1,0, in_valid=0 for 3 cycles, then 1,1 -> one pulse on the cycle after final 1; detector_out stays 0 during the gap.
- Stream 1,0,1, reset=0 one cycle, then 1 -> no pulse; match_count=0; cfg_err=1 until cfg_load len 4 is re-issued.
- CNT_W=2, pattern 2'b11 len 2, overlap=1, six 1s -> 5 pulses; match_count saturates at 3. clear_count with a same-cycle match -> count 0.
- cfg_load len=9 (PAT_W=8) -> cfg_err=1, no pulses for any stream. cfg_load len=0 -> cfg_err=1. Legal reload -> cfg_err=0, history cleared.
